// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM states and
// instruction field positions.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_LDI = 4'b0000;
  localparam logic [3:0] OP_INC = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_INC) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu_regfile4.sv
// 4-entry register file: one write port, two operand reads and a debug read,
// all reads combinational; write and reset take effect on the clock edge.
module alu_regfile4
  import alu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [1:0]   waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [1:0]   ra_addr_i,
  output logic [W-1:0] ra_data_o,
  input  logic [1:0]   rb_addr_i,
  output logic [W-1:0] rb_data_o,
  input  logic [1:0]   dbg_addr_i,
  output logic [W-1:0] dbg_data_o
);

  logic [W-1:0] regs_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o  = regs_q[ra_addr_i];
  assign rb_data_o  = regs_q[rb_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to the external ALU, holds its inputs SETTLE
// cycles, writes back and presents the result until res_ready (no overlap).
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_instr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_rst,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_flag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_rd,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_err,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             alu_rst_q, alu_rst_d;
  logic [1:0]       rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       res_rd_q, res_rd_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_err_q, res_err_d;

  logic [3:0]       f_op;
  logic [1:0]       f_rd, f_rs;
  logic [7:0]       f_imm;
  logic [WIDTH-1:0] ldi_val, rf_a, rf_b;
  logic             rf_we;
  logic [1:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  assign f_op    = cmd_instr[OP_HI:OP_LO];
  assign f_rd    = cmd_instr[RD_HI:RD_LO];
  assign f_rs    = cmd_instr[RS_HI:RS_LO];
  assign f_imm   = cmd_instr[IMM_HI:IMM_LO];
  assign ldi_val = {{(WIDTH-8){1'b0}}, f_imm};

  alu_regfile4 #(.W(WIDTH)) u_rf (
    .clk        (clk),
    .rst        (rst),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .ra_addr_i  (f_rd),
    .ra_data_o  (rf_a),
    .rb_addr_i  (f_rs),
    .rb_data_o  (rf_b),
    .dbg_addr_i (dbg_sel),
    .dbg_data_o (dbg_data)
  );

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    alu_rst_d  = alu_rst_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    res_rd_d   = res_rd_q;
    res_data_d = res_data_q;
    res_zero_d = res_zero_q;
    res_err_d  = res_err_q;
    rf_we      = 1'b0;
    rf_waddr   = rd_q;
    rf_wdata   = alu_y;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (is_alu_op(f_op)) begin
            // Operands are latched here, so rd==rs reads the pre-writeback value.
            alu_a_d   = rf_a;
            alu_b_d   = rf_b;
            alu_op_d  = f_op;
            alu_rst_d = 1'b0;
            rd_d      = f_rd;
            cnt_d     = '0;
            state_d   = ST_EXEC;
          end else if (f_op == OP_LDI) begin
            rf_we      = 1'b1;
            rf_waddr   = f_rd;
            rf_wdata   = ldi_val;
            res_rd_d   = f_rd;
            res_data_d = ldi_val;
            res_zero_d = (f_imm == 8'h00);
            res_err_d  = 1'b0;
            state_d    = ST_RESP;
          end else begin
            res_rd_d   = f_rd;
            res_data_d = '0;
            res_zero_d = 1'b0;
            res_err_d  = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SETTLE - 1)) begin
          rf_we      = 1'b1;
          res_rd_d   = rd_q;
          res_data_d = alu_y;
          res_zero_d = alu_flag;
          res_err_d  = 1'b0;
          alu_rst_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      alu_rst_q  <= 1'b1;
      rd_q       <= '0;
      cnt_q      <= '0;
      res_rd_q   <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      alu_rst_q  <= alu_rst_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      res_rd_q   <= res_rd_d;
      res_data_q <= res_data_d;
      res_zero_q <= res_zero_d;
      res_err_q  <= res_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign res_valid = (state_q == ST_RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_rst   = alu_rst_q;
  assign res_rd    = res_rd_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: SETTLE=1 and SETTLE=3 instances behind one set of
// bench signals, a per-cycle reference model and directed literal checks.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, cmd_valid, res_ready;
  logic [15:0] cmd_instr;
  logic [1:0]  dbg_sel;

  logic        r1, r3;
  logic        cr1, cr3, ar1, ar3, rv1, rv3, rz1, rz3, re1, re3, f1, f3;
  logic [15:0] a1, a3, b1, b3, y1, y3, d1, d3, dd1, dd3;
  logic [3:0]  op1, op3;
  logic [1:0]  rr1, rr3;

  logic        cmd_ready, alu_rst, res_valid, res_zero, res_err;
  logic [15:0] alu_a, alu_b, res_data, dbg_data;
  logic [3:0]  alu_op;
  logic [1:0]  res_rd;

  // External ALU: INC increments operand b (the rs register).
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op, input logic ar);
    if (ar) return 16'h0000;
    case (op)
      4'b0001: return b + 16'h0001;
      4'b0101: return a + b;
      4'b0110: return a - b;
      4'b0111: return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  assign y1 = alu_f(a1, b1, op1, ar1);
  assign y3 = alu_f(a3, b3, op3, ar3);
  assign f1 = (y1 == 16'h0000);
  assign f3 = (y3 == 16'h0000);
  assign r1 = rst | sel;
  assign r3 = rst | ~sel;

  assign cmd_ready = sel ? cr3 : cr1;
  assign alu_a     = sel ? a3  : a1;
  assign alu_b     = sel ? b3  : b1;
  assign alu_op    = sel ? op3 : op1;
  assign alu_rst   = sel ? ar3 : ar1;
  assign res_valid = sel ? rv3 : rv1;
  assign res_rd    = sel ? rr3 : rr1;
  assign res_data  = sel ? d3  : d1;
  assign res_zero  = sel ? rz3 : rz1;
  assign res_err   = sel ? re3 : re1;
  assign dbg_data  = sel ? dd3 : dd1;

  alu_issue_ctrl #(.WIDTH(16), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(r1), .cmd_valid(cmd_valid), .cmd_ready(cr1), .cmd_instr(cmd_instr),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_rst(ar1), .alu_y(y1), .alu_flag(f1),
    .res_valid(rv1), .res_ready(res_ready), .res_rd(rr1), .res_data(d1), .res_zero(rz1),
    .res_err(re1), .dbg_sel(dbg_sel), .dbg_data(dd1)
  );

  alu_issue_ctrl #(.WIDTH(16), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(r3), .cmd_valid(cmd_valid), .cmd_ready(cr3), .cmd_instr(cmd_instr),
    .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_rst(ar3), .alu_y(y3), .alu_flag(f3),
    .res_valid(rv3), .res_ready(res_ready), .res_rd(rr3), .res_data(d3), .res_zero(rz3),
    .res_err(re3), .dbg_sel(dbg_sel), .dbg_data(dd3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus a countdown to the result.
  bit          m_on = 1'b0;
  bit          m_idle, m_rv;
  int          m_left;
  logic [15:0] m_r [4];
  logic [1:0]  p_rd;
  logic [15:0] p_data, p_a, p_b;
  logic [3:0]  p_op;
  bit          p_zero, p_err, p_wr;
  logic [1:0]  e_rd;
  logic [15:0] e_data;
  bit          e_zero, e_err;

  initial begin
    forever begin
      @(negedge clk);
      if (m_on) begin
        chk1("cmd_ready", cmd_ready, m_idle && !rst);
        chk1("res_valid", res_valid, m_rv);
        chk1("alu_rst", alu_rst, m_left == 0);
        if (m_left > 0) begin
          chk16("alu_a", alu_a, p_a);
          chk16("alu_b", alu_b, p_b);
          chk16("alu_op", 16'(alu_op), 16'(p_op));
        end
        if (m_rv) begin
          chk16("res_rd", 16'(res_rd), 16'(e_rd));
          chk16("res_data", res_data, e_data);
          chk1("res_zero", res_zero, e_zero);
          chk1("res_err", res_err, e_err);
        end
        if (!rst) chk16("dbg_data", dbg_data, m_r[dbg_sel]);
      end
      // Advance the model by the upcoming rising edge.
      if (rst) begin
        for (int i = 0; i < 4; i++) m_r[i] = 16'h0000;
        m_idle = 1'b1; m_rv = 1'b0; m_left = 0; m_on = 1'b1;
      end else if (m_on) begin
        bit commit;
        commit = 1'b0;
        if (m_idle && cmd_valid) begin
          logic [3:0] op;
          logic [1:0] rd, rs;
          op = cmd_instr[15:12]; rd = cmd_instr[11:10]; rs = cmd_instr[9:8];
          p_rd = rd; p_a = m_r[rd]; p_b = m_r[rs]; p_op = op; p_err = 1'b0; p_wr = 1'b1;
          case (op)
            4'h0: p_data = {8'h00, cmd_instr[7:0]};
            4'h1: p_data = m_r[rs] + 16'h0001;
            4'h5: p_data = m_r[rd] + m_r[rs];
            4'h6: p_data = m_r[rd] - m_r[rs];
            4'h7: p_data = m_r[rd] ^ m_r[rs];
            default: begin p_data = 16'h0000; p_err = 1'b1; p_wr = 1'b0; end
          endcase
          p_zero = !p_err && (p_data == 16'h0000);
          m_idle = 1'b0;
          if (op inside {4'h1, 4'h5, 4'h6, 4'h7}) m_left = sel ? 3 : 1;
          else commit = 1'b1;
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) commit = 1'b1;
        end else if (m_rv && res_ready) begin
          m_rv = 1'b0; m_idle = 1'b1;
        end
        if (commit) begin
          if (p_wr) m_r[p_rd] = p_data;
          e_rd = p_rd; e_data = p_data; e_zero = p_zero; e_err = p_err; m_rv = 1'b1;
        end
      end
    end
  end

  int          r_lat;
  logic [15:0] r_a, r_b, r_data, r_dbg;
  logic [3:0]  r_op;
  logic [1:0]  r_rd;
  logic        r_zero, r_err;

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // r_lat = edges after the accept edge up to the one that raised res_valid.
  task automatic do_op(input logic [15:0] ins, input bit hs);
    bit acc;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_instr = ins;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk); acc = cmd_ready;
      sync();
    end
    cmd_valid = 1'b0;
    chk1("accept", acc, 1'b1);
    r_lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) begin r_a = alu_a; r_b = alu_b; r_op = alu_op; end
      if (res_valid) begin r_lat = n; break; end
    end
    r_data = res_data; r_zero = res_zero; r_err = res_err; r_rd = res_rd; r_dbg = dbg_data;
    if (hs) sync();
  endtask

  task automatic expect_res(input string name, input int lat, input logic [15:0] data,
                            input logic zero, input logic err, input logic [1:0] rd);
    chk16({name, "_lat"}, 16'(r_lat), 16'(lat));
    chk16({name, "_data"}, r_data, data);
    chk1({name, "_zero"}, r_zero, zero);
    chk1({name, "_err"}, r_err, err);
    chk16({name, "_rd"}, 16'(r_rd), 16'(rd));
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_instr = 16'h0000;
    res_ready = 1'b1; dbg_sel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk16("rst_res_data", res_data, 16'h0000);
    chk16("rst_alu_a", alu_a, 16'h0000);
    chk16("rst_alu_b", alu_b, 16'h0000);
    chk16("rst_alu_op", 16'(alu_op), 16'h0000);
    chk1("rst_alu_rst", alu_rst, 1'b1);
    chk1("rst_res_err", res_err, 1'b0);
    sync(); rst = 1'b0;
    @(negedge clk);
    chk1("idle_cmd_ready", cmd_ready, 1'b1);
    sync();

    // SETTLE = 1
    dbg_sel = 2'd1;
    do_op(16'h0405, 1'b1);                       // LDI R1,0x05
    expect_res("ldi_r1", 0, 16'h0005, 1'b0, 1'b0, 2'd1);
    chk16("ldi_r1_dbg", r_dbg, 16'h0005);
    dbg_sel = 2'd2;
    do_op(16'h0803, 1'b1);                       // LDI R2,0x03
    expect_res("ldi_r2", 0, 16'h0003, 1'b0, 1'b0, 2'd2);
    dbg_sel = 2'd1;
    do_op(16'h5600, 1'b1);                       // ADD R1,R2
    chk16("add_alu_a", r_a, 16'h0005);
    chk16("add_alu_b", r_b, 16'h0003);
    chk16("add_alu_op", 16'(r_op), 16'h0005);
    expect_res("add", 1, 16'h0008, 1'b0, 1'b0, 2'd1);
    chk16("add_dbg", r_dbg, 16'h0008);
    do_op(16'h6A00, 1'b1);                       // SUB R2,R2
    expect_res("sub_self", 1, 16'h0000, 1'b1, 1'b0, 2'd2);
    do_op(16'h6900, 1'b1);                       // SUB R2,R1 -> 0-8
    expect_res("sub_wrap", 1, 16'hFFF8, 1'b0, 1'b0, 2'd2);
    do_op(16'h0000, 1'b1);                       // LDI R0,0x00
    expect_res("ldi_zero", 0, 16'h0000, 1'b1, 1'b0, 2'd0);
    do_op(16'h0C01, 1'b1);                       // LDI R3,0x01
    do_op(16'h6300, 1'b1);                       // SUB R0,R3 -> FFFF
    expect_res("sub_ffff", 1, 16'hFFFF, 1'b0, 1'b0, 2'd0);
    do_op(16'h1C00, 1'b1);                       // INC R3 <- R0+1
    chk16("inc_alu_b", r_b, 16'hFFFF);
    expect_res("inc_wrap", 1, 16'h0000, 1'b1, 1'b0, 2'd3);

    // Illegal opcode held under backpressure; a new command must be ignored.
    res_ready = 1'b0;
    do_op(16'hF500, 1'b0);
    expect_res("illegal", 0, 16'h0000, 1'b0, 1'b1, 2'd1);
    sync();
    cmd_valid = 1'b1; cmd_instr = 16'h0411;
    repeat (5) begin
      @(negedge clk);
      chk1("hold_valid", res_valid, 1'b1);
      chk1("hold_ready", cmd_ready, 1'b0);
      chk1("hold_err", res_err, 1'b1);
      chk16("hold_data", res_data, 16'h0000);
    end
    sync();
    cmd_valid = 1'b0; res_ready = 1'b1;
    sync();
    @(negedge clk);
    chk16("r1_unchanged", dbg_data, 16'h0008);
    chk16("model_r2", m_r[2], 16'hFFF8);
    chk16("model_r3", m_r[3], 16'h0000);
    sync();

    // SETTLE = 3 with reset in the middle of EXEC
    sel = 1'b1; rst = 1'b1;
    sync(); sync();
    rst = 1'b0;
    do_op(16'h0803, 1'b1);                       // LDI R2,0x03
    expect_res("s3_ldi", 0, 16'h0003, 1'b0, 1'b0, 2'd2);
    cmd_valid = 1'b1; cmd_instr = 16'h5600;      // ADD R1,R2
    @(negedge clk);
    chk1("s3_ready", cmd_ready, 1'b1);
    sync();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk1("s3_exec_alu_rst", alu_rst, 1'b0);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0; dbg_sel = 2'd1;
    repeat (6) begin
      @(negedge clk);
      chk1("s3_abort_valid", res_valid, 1'b0);
      chk1("s3_abort_alu_rst", alu_rst, 1'b1);
      chk16("s3_abort_r1", dbg_data, 16'h0000);
    end
    sync();
    do_op(16'h0807, 1'b1);                       // LDI R2,0x07
    expect_res("s3_ldi7", 0, 16'h0007, 1'b0, 1'b0, 2'd2);
    do_op(16'h5600, 1'b1);                       // ADD R1,R2
    chk16("s3_add_alu_b", r_b, 16'h0007);
    expect_res("s3_add", 3, 16'h0007, 1'b0, 1'b0, 2'd1);
    repeat (3) sync();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
